uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 234, clock cycles per UART bit period; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; power of two, 2..256.
REQ-003 clk_i  input  1  single system clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 data_i  input  8  byte to transmit.
REQ-006 valid_i  input  1  data_i valid; byte accepted on cycle where valid_i && ready_o.
REQ-007 ready_o  output  1  FIFO can accept a byte (not full).
REQ-008 uart_tx_o  output  1  serial line, 8N1, idle high.
REQ-009 busy_o  output  1  frame in progress or FIFO non-empty.
REQ-010 fifo_count_o  output  $clog2(FIFO_DEPTH)+1  bytes currently queued (excluding byte in shifter).

Function
REQ-011 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 IDLE: uart_tx_o=1; if fifo_count_o>0, pop head into shift register and enter START next cycle.
REQ-014 START: uart_tx_o=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-015 DATA: drive shift[idx] for CLKS_PER_BIT cycles; after idx 7 enter STOP; 3-bit index, no wrap beyond 7.
REQ-016 STOP: uart_tx_o=1 for CLKS_PER_BIT cycles; at end, if FIFO non-empty pop and enter START directly (no idle gap), else IDLE.
REQ-017 Latency: byte written into empty FIFO while IDLE SHALL produce falling start edge on uart_tx_o exactly 2 cycles after the accept edge.
REQ-018 uart_tx_o SHALL be registered (glitch-free).
REQ-019 ready_o SHALL be low when fifo_count_o==FIFO_DEPTH, even if a pop occurs that cycle.
REQ-020 Simultaneous push and pop SHALL leave fifo_count_o unchanged and preserve byte order.
REQ-021 Pop SHALL use the registered count; a byte pushed in a cycle is not popped in the same cycle.
REQ-022 valid_i while ready_o=0 SHALL be ignored; no data loss or corruption of queued bytes.
REQ-023 Read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 busy_o SHALL be low only when state==IDLE and fifo_count_o==0.

Reset
REQ-025 On rst_i assertion, asynchronously: uart_tx_o=1, state=IDLE, bit counter and index=0, FIFO emptied, fifo_count_o=0, ready_o=1, busy_o=0.
REQ-026 Reset mid-frame SHALL abort the frame immediately; line returns high with no further bits sent.
REQ-027 First valid_i accept possible on first rising edge after rst_i deasserts.

Structure
REQ-028 Shared package nano6502_pkg SHALL hold the UART state enum typedef and default CLKS_PER_BIT constant (shared with the UART receiver).
REQ-029 FIFO SHALL be a separate sub-module sync_fifo (parameterized width/depth, push/pop/full/empty/count); FSM and baud counter live in uart_tx.
REQ-030 No dependence on the receiver; same baud constant guarantees loopback compatibility.

Verification (bench CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Push 0xA5 after reset -> start edge 2 cycles later; line samples 0,1,0,1,0,0,1,0,1,1 each 4 cycles; busy_o low 1 cycle after stop bit ends.
REQ-032 Push 0x00,0xFF,0x55 back-to-back -> three frames, stop of each directly followed by next start, 120 cycles total, correct order.
REQ-033 Hold valid_i 6 cycles with 0x01..0x06 while idle -> ready_o drops when count=4; exactly bytes accepted while ready_o=1 transmitted, ignored bytes never appear.
REQ-034 Full FIFO, push attempted on same cycle as pop -> push rejected, count 4->3, order intact.
REQ-035 Assert rst_i during DATA bit 3 of 0x3C -> uart_tx_o=1 asynchronously, count=0, no further frame; subsequent push 0x81 transmits cleanly.
REQ-036 Loopback uart_tx_o into the existing UART receiver, random 64 bytes -> all received identically.

Source files
------------

// File: rtl/nano6502_pkg.sv
// Definitions shared by the nano6502 UART transmitter and receiver.
// Both sides use the same default baud divisor so they interoperate in loopback.
package nano6502_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_CLKS_PER_BIT = 234;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Full/empty come from the registered count, so a push and a pop never see the same-cycle entry.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO.
// The serial output is registered from the current state, so the line lags the FSM by one cycle.
module uart_tx
    import nano6502_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    localparam int CNTW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [7:0]      data_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic            uart_tx_o,
    output logic            busy_o,
    output logic [CNTW-1:0] fifo_count_o
);

    localparam int            BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          tail_q;
    logic          bit_end;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_data;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (valid_i),
        .pop_i   (fifo_pop),
        .data_i  (data_i),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    assign ready_o   = !fifo_full;
    assign uart_tx_o = tx_q;
    // tail_q keeps busy high until the registered stop bit has fully left the line.
    assign busy_o    = (state_q != UART_IDLE) || (fifo_count_o != '0) || tail_q;
    assign bit_end   = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = 1'b1;
        fifo_pop = 1'b0;
        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_data;
                    baud_d   = '0;
                    state_d  = UART_START;
                end
            end
            UART_START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    baud_d  = '0;
                    idx_d   = 3'd0;
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            UART_DATA: begin
                tx_d = shift_q[idx_q];
                if (bit_end) begin
                    baud_d = '0;
                    if (idx_q == 3'd7) state_d = UART_STOP;
                    else               idx_d   = idx_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            UART_STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    baud_d = '0;
                    // Chain straight into the next start bit when more bytes are queued.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_data;
                        state_d  = UART_START;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= UART_IDLE;
            baud_q  <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            tail_q  <= (state_q != UART_IDLE);
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized checks of uart_tx at 4 clocks per bit with a 4-entry FIFO.
// Expected line levels come from the 8N1 frame definition; received bytes from a mid-bit sampler.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       valid;
    logic       ready_o;
    logic       uart_tx_o;
    logic       busy_o;
    logic [2:0] fifo_count_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .data_i       (data_in),
        .valid_i      (valid),
        .ready_o      (ready_o),
        .uart_tx_o    (uart_tx_o),
        .busy_o       (busy_o),
        .fifo_count_o (fifo_count_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level of bit slot i (0 = start, 1..8 = data LSB first, 9 = stop).
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    // Behavioural receiver: find the start edge, then sample at mid-bit.
    task automatic rx_byte(output logic [7:0] b, output logic ok);
        int waited;
        waited = 0;
        ok     = 1'b1;
        b      = 8'h00;
        while (uart_tx_o !== 1'b0 && waited < 200) begin
            step();
            waited++;
        end
        if (uart_tx_o !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (CPB / 2) step();
        if (uart_tx_o !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) step();
            b[i] = uart_tx_o;
        end
        repeat (CPB) step();
        if (uart_tx_o !== 1'b1) ok = 1'b0;
    endtask

    task automatic rx_expect(input string tag);
        logic [7:0] b;
        logic       ok;
        logic [7:0] e;
        rx_byte(b, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check({tag, "_framing"}, 32'(ok), 32'd1);
        check({tag, "_data"}, 32'(b), 32'(e));
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        int lows;
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (uart_tx_o !== 1'b1) lows++;
            step();
        end
        check(tag, 32'(lows), 32'd0);
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        logic [7:0] bytes3 [3];
        bytes3[0] = 8'h00;
        bytes3[1] = 8'hFF;
        bytes3[2] = 8'h55;

        rst     = 1'b1;
        valid   = 1'b0;
        data_in = 8'h00;
        #12;
        check("rst_line",  32'(uart_tx_o),    32'd1);
        check("rst_ready", 32'(ready_o),      32'd1);
        check("rst_busy",  32'(busy_o),       32'd0);
        check("rst_count", 32'(fifo_count_o), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single byte 0xA5 accepted on the first edge after reset release.
        valid   = 1'b1;
        data_in = 8'hA5;
        step();
        valid = 1'b0;
        check("a5_count_after_push", 32'(fifo_count_o), 32'd1);
        check("a5_busy_after_push",  32'(busy_o),       32'd1);
        step();
        check("a5_line_before_start", 32'(uart_tx_o), 32'd1);
        step();
        for (int k = 0; k < FRAME; k++) begin
            check("a5_line", 32'(uart_tx_o), 32'(frame_bit(8'hA5, k / CPB)));
            check("a5_busy", 32'(busy_o), 32'd1);
            step();
        end
        check("a5_busy_done", 32'(busy_o), 32'd0);
        check_quiet("a5_quiet", 12);

        // Three bytes back-to-back: contiguous frames, no idle gap.
        for (int i = 0; i < 3; i++) begin
            valid   = 1'b1;
            data_in = bytes3[i];
            step();
        end
        valid = 1'b0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            check("b2b_line", 32'(uart_tx_o), 32'(frame_bit(bytes3[k / FRAME], (k % FRAME) / CPB)));
            step();
        end
        check("b2b_busy_done",  32'(busy_o),       32'd0);
        check("b2b_count_done", 32'(fifo_count_o), 32'd0);
        check_quiet("b2b_quiet", 12);

        // valid held 6 cycles: first byte moves to the shifter, four fill the FIFO, sixth refused.
        for (int i = 0; i < 6; i++) begin
            valid   = 1'b1;
            data_in = 8'(i + 1);
            check("hold_ready", 32'(ready_o), 32'(i < 5));
            step();
        end
        check("hold_count_full", 32'(fifo_count_o), 32'd4);
        // Keep pushing 0x77 into the full FIFO up to and including the pop edge.
        for (int k = 5; k < 41; k++) begin
            data_in = 8'h77;
            check("full_line",  32'(uart_tx_o),    32'(frame_bit(8'h01, (k - 2) / CPB)));
            check("full_ready", 32'(ready_o),      32'd0);
            check("full_count", 32'(fifo_count_o), 32'd4);
            step();
        end
        valid = 1'b0;
        check("pop_with_push_count", 32'(fifo_count_o), 32'd3);
        check("pop_with_push_line",  32'(uart_tx_o),    32'd1);
        for (int i = 2; i <= 5; i++) exp_q.push_back(8'(i));
        for (int i = 0; i < 4; i++) rx_expect("hold_rx");
        check_quiet("hold_quiet", 60);
        check("hold_busy_done", 32'(busy_o), 32'd0);

        // Reset in the middle of data bit 3 of 0x3C with 0x99 still queued.
        valid   = 1'b1;
        data_in = 8'h3C;
        step();
        data_in = 8'h99;
        step();
        valid = 1'b0;
        repeat (18) step();
        check("mid_line_bit3", 32'(uart_tx_o),    32'd1);
        check("mid_count",     32'(fifo_count_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_line",  32'(uart_tx_o),    32'd1);
        check("async_rst_count", 32'(fifo_count_o), 32'd0);
        check("async_rst_ready", 32'(ready_o),      32'd1);
        check("async_rst_busy",  32'(busy_o),       32'd0);
        step();
        step();
        rst     = 1'b0;
        valid   = 1'b1;
        data_in = 8'h81;
        step();
        valid = 1'b0;
        check("post_rst_count", 32'(fifo_count_o), 32'd1);
        step();
        check("post_rst_line_pop", 32'(uart_tx_o), 32'd1);
        step();
        check("post_rst_start", 32'(uart_tx_o), 32'd0);
        exp_q.push_back(8'h81);
        rx_expect("post_rst_rx");
        check_quiet("post_rst_quiet", 60);
        check("post_rst_busy", 32'(busy_o), 32'd0);

        // Randomized loopback: 64 bytes pushed with random gaps, decoded concurrently.
        fork
            begin : pusher
                int sent;
                int budget;
                sent   = 0;
                budget = 0;
                while (sent < 64 && budget < 20000) begin
                    valid   = ($urandom_range(0, 3) != 0);
                    data_in = 8'($urandom_range(0, 255));
                    if (valid && ready_o) begin
                        exp_q.push_back(data_in);
                        sent++;
                    end
                    step();
                    budget++;
                end
                valid = 1'b0;
                check("lb_push_budget", 32'(sent), 32'd64);
            end
            begin : receiver
                for (int i = 0; i < 64; i++) rx_expect("lb");
            end
        join
        check_quiet("lb_quiet", 20);
        check("lb_busy_done",  32'(busy_o),       32'd0);
        check("lb_queue_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
